// File: rtl/reg_file_mp.sv
// Multi-port integer register file with two write ports, write-to-read bypass
// and a per-register busy scoreboard used by the issue stage to stall.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_READ*AW-1:0]    rd_index,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic                      wr0_en,
  input  logic [AW-1:0]             wr0_index,
  input  logic [WIDTH-1:0]          wr0_data,
  input  logic                      wr1_en,
  input  logic [AW-1:0]             wr1_index,
  input  logic [WIDTH-1:0]          wr1_data,
  input  logic                      issue_en,
  input  logic [AW-1:0]             issue_index,
  input  logic                      flush,
  output logic [AW:0]               busy_count
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic [DEPTH-1:0] wr_clr;

  logic wr0_ok, wr1_ok;

  // Register 0 swallows writes when it is hard-wired to zero.
  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_index == '0));
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_index == '0));

  // Storage update; W1 is applied last so it wins a same-index collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr0_ok) regs_q[wr0_index] <= wr0_data;
      if (wr1_ok) regs_q[wr1_index] <= wr1_data;
    end
  end

  // Registers completing a write this cycle (either port).
  always_comb begin
    wr_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((wr0_en && (wr0_index == AW'(i))) || (wr1_en && (wr1_index == AW'(i))))
        wr_clr[i] = 1'b1;
    end
  end

  // Scoreboard next state: flush beats issue, issue beats write completion.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_en && (issue_index == AW'(i))) busy_d[i] = 1'b1;
        else if (wr_clr[i])                      busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Population count of the next scoreboard state, registered alongside it.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
  end

  // Scoreboard and busy counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] val;

    assign idx = rd_index[p*AW +: AW];

    // Read mux with 0-cycle bypass; W1 has priority over W0, outputs forced low in reset.
    always_comb begin
      if (!reset_n)                              val = '0;
      else if ((ZERO_REG != 0) && (idx == '0))   val = '0;
      else if (wr1_en && (wr1_index == idx))     val = wr1_data;
      else if (wr0_en && (wr0_index == idx))     val = wr0_data;
      else                                       val = regs_q[idx];
    end

    assign rd_data[p*WIDTH +: WIDTH] = val;
    assign rd_busy[p] = reset_n & busy_q[idx] & ~wr_clr[idx];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a 32x32/2-read instance and a 64x64/4-read instance
// share one stimulus stream and are checked against an array-based model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  rd_idx [4];
  logic        wr0_en, wr1_en, issue_en, flush;
  logic [5:0]  wr0_idx, wr1_idx, issue_idx;
  logic [63:0] wr0_dat, wr1_dat;

  logic [63:0]  s_rd_data;
  logic [1:0]   s_rd_busy;
  logic [5:0]   s_busy_count;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [6:0]   b_busy_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mreg  [2][64];
  bit          mbusy [2][64];

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) u_small (
    .clk(clk), .reset_n(reset_n),
    .rd_index({rd_idx[1][4:0], rd_idx[0][4:0]}),
    .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr0_en(wr0_en), .wr0_index(wr0_idx[4:0]), .wr0_data(wr0_dat[31:0]),
    .wr1_en(wr1_en), .wr1_index(wr1_idx[4:0]), .wr1_data(wr1_dat[31:0]),
    .issue_en(issue_en), .issue_index(issue_idx[4:0]),
    .flush(flush), .busy_count(s_busy_count)
  );

  reg_file_mp #(.WIDTH(64), .DEPTH(64), .NUM_READ(4), .ZERO_REG(1)) u_big (
    .clk(clk), .reset_n(reset_n),
    .rd_index({rd_idx[3], rd_idx[2], rd_idx[1], rd_idx[0]}),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(wr0_en), .wr0_index(wr0_idx), .wr0_data(wr0_dat),
    .wr1_en(wr1_en), .wr1_index(wr1_idx), .wr1_data(wr1_dat),
    .issue_en(issue_en), .issue_index(issue_idx),
    .flush(flush), .busy_count(b_busy_count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(int c);
    return (c == 0) ? 32 : 64;
  endfunction

  function automatic logic [63:0] mask_of(int c);
    return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] obs_rd(int c, int p);
    if (c == 0) return {32'b0, s_rd_data[p*32 +: 32]};
    return b_rd_data[p*64 +: 64];
  endfunction

  function automatic logic obs_busy(int c, int p);
    if (c == 0) return s_rd_busy[p];
    return b_rd_busy[p];
  endfunction

  // Architectural read value seen this cycle: zero register, then newest write, then storage.
  function automatic logic [63:0] exp_rd(int c, int raw);
    int d = depth_of(c);
    int i = raw % d;
    if (!reset_n || i == 0) return 64'd0;
    if (wr1_en && (int'(wr1_idx) % d) == i) return wr1_dat & mask_of(c);
    if (wr0_en && (int'(wr0_idx) % d) == i) return wr0_dat & mask_of(c);
    return mreg[c][i];
  endfunction

  function automatic logic exp_busy(int c, int raw);
    int d = depth_of(c);
    int i = raw % d;
    if (!reset_n) return 1'b0;
    if (wr0_en && (int'(wr0_idx) % d) == i) return 1'b0;
    if (wr1_en && (int'(wr1_idx) % d) == i) return 1'b0;
    return mbusy[c][i];
  endfunction

  function automatic int exp_count(int c);
    int n = 0;
    if (!reset_n) return 0;
    for (int i = 0; i < 64; i++) n += int'(mbusy[c][i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 64; i++) begin
        mreg[c][i]  = 64'd0;
        mbusy[c][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_clear();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      int d  = depth_of(c);
      int a0 = int'(wr0_idx) % d;
      int a1 = int'(wr1_idx) % d;
      int ai = int'(issue_idx) % d;
      if (wr0_en && a0 != 0) mreg[c][a0] = wr0_dat & mask_of(c);
      if (wr1_en && a1 != 0) mreg[c][a1] = wr1_dat & mask_of(c);
      if (flush) begin
        for (int i = 0; i < 64; i++) mbusy[c][i] = 1'b0;
      end else begin
        if (wr0_en) mbusy[c][a0] = 1'b0;
        if (wr1_en) mbusy[c][a1] = 1'b0;
        if (issue_en && ai != 0) mbusy[c][ai] = 1'b1;
      end
    end
  endtask

  // Check all outputs for the inputs currently applied, then advance one clock.
  task automatic step();
    #1;
    for (int c = 0; c < 2; c++) begin
      int nr = (c == 0) ? 2 : 4;
      for (int p = 0; p < nr; p++) begin
        check_val($sformatf("rd_data c%0d p%0d", c, p), obs_rd(c, p), exp_rd(c, int'(rd_idx[p])));
        check_val($sformatf("rd_busy c%0d p%0d", c, p), 64'(obs_busy(c, p)),
                  64'(exp_busy(c, int'(rd_idx[p]))));
      end
    end
    check_val("busy_count c0", 64'(s_busy_count), 64'(exp_count(0)));
    check_val("busy_count c1", 64'(b_busy_count), 64'(exp_count(1)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0; flush = 0;
    wr0_idx = 0; wr1_idx = 0; issue_idx = 0;
    wr0_dat = 0; wr1_dat = 0;
    for (int p = 0; p < 4; p++) rd_idx[p] = 6'($urandom_range(0, 63));
  endtask

  task automatic rand_inputs();
    wr0_en    = ($urandom_range(0, 2) != 0);
    wr1_en    = ($urandom_range(0, 2) != 0);
    issue_en  = ($urandom_range(0, 1) != 0);
    flush     = ($urandom_range(0, 15) == 0);
    wr0_idx   = 6'($urandom_range(0, 63));
    wr1_idx   = ($urandom_range(0, 3) == 0) ? wr0_idx : 6'($urandom_range(0, 63));
    issue_idx = ($urandom_range(0, 3) == 0) ? wr0_idx : 6'($urandom_range(0, 63));
    wr0_dat   = {$urandom, $urandom};
    wr1_dat   = {$urandom, $urandom};
    for (int p = 0; p < 4; p++) begin
      case ($urandom_range(0, 4))
        0:       rd_idx[p] = wr0_idx;
        1:       rd_idx[p] = wr1_idx;
        2:       rd_idx[p] = issue_idx;
        default: rd_idx[p] = 6'($urandom_range(0, 63));
      endcase
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    step();
    reset_n = 1'b1;
    step();

    // Random writes, then reset asserted while writes are still being driven.
    for (int k = 0; k < 20; k++) begin rand_inputs(); step(); end
    rand_inputs();
    reset_n = 1'b0;
    step();
    rand_inputs();
    step();
    idle();
    reset_n = 1'b1;
    for (int p = 0; p < 4; p++) rd_idx[p] = 6'(p * 7 + 5);
    step();
    check_val("post-reset count", 64'(b_busy_count), 64'd0);

    // Same-cycle write/read bypass, then stored value.
    idle(); wr0_en = 1; wr0_idx = 5; wr0_dat = 64'hDEAD_BEEF; rd_idx[0] = 5;
    step();
    idle(); rd_idx[0] = 5;
    #1 check_val("stored 5", obs_rd(0, 0), 64'hDEAD_BEEF);
    step();

    // Write collision: W1 wins.
    idle(); wr0_en = 1; wr0_idx = 7; wr0_dat = 64'h11;
    wr1_en = 1; wr1_idx = 7; wr1_dat = 64'h22; rd_idx[1] = 7;
    step();
    idle(); rd_idx[1] = 7;
    #1 check_val("collide 7", obs_rd(1, 1), 64'h22);
    step();

    // Issue then complete via W1.
    idle(); issue_en = 1; issue_idx = 3;
    step();
    idle(); rd_idx[0] = 3;
    #1 check_val("issued cnt", 64'(s_busy_count), 64'd1);
    step();
    idle(); wr1_en = 1; wr1_idx = 3; wr1_dat = 64'h55; rd_idx[0] = 3;
    #1 check_val("clr busy", 64'(s_rd_busy[0]), 64'd0);
    step();
    idle();
    #1 check_val("cleared cnt", 64'(s_busy_count), 64'd0);

    // Issue wins over same-cycle write; flush wins over issue.
    idle(); issue_en = 1; issue_idx = 9; wr0_en = 1; wr0_idx = 9; wr0_dat = 64'h99;
    step();
    idle(); rd_idx[2] = 9;
    #1 check_val("issue>write", 64'(b_rd_busy[2]), 64'd1);
    step();
    idle(); flush = 1; issue_en = 1; issue_idx = 9;
    step();
    idle();
    #1 check_val("flush cnt", 64'(b_busy_count), 64'd0);

    // Register 0 is constant zero and never busy.
    idle(); wr0_en = 1; wr0_idx = 0; wr0_dat = '1; issue_en = 1; issue_idx = 0;
    rd_idx[0] = 0; rd_idx[3] = 0;
    step();
    idle(); rd_idx[0] = 0; rd_idx[3] = 0;
    #1 check_val("zero reg", obs_rd(1, 3), 64'd0);
    step();

    // Long random run, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      reset_n = ($urandom_range(0, 99) != 0);
      step();
    end
    reset_n = 1'b1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
